idct: RTL and testbench
=======================

// Module: idct
// PURPOSE
//  Inverse 8x8 DCT for the decode path. It reconstructs one YCbCr pixel at block position (x,y)
//  from 64 signed fixed-point coefficients.
//  - Coefficients are read from an external coefficient buffer through a 1-cycle-latency read port.
//  - The basis term cos(x,u)*cos(y,v) comes from dct_constants.mem, addressed u*512+v*64+x*8+y.
//  - Output is a packed 24-bit {Y,Cb,Cr} pixel, clamped to 0..255, for the pixel writer.
// PARAMETERS
//  q_full       32                   total fixed-point width, signed
//  q_half       16                   fractional bits
//  address_len  12                   constant-ROM address width (>=12)
//  acc_guard    6                    accumulator guard bits above q_full
//  const_file   "./dct_constants.mem" basis-constant ROM image
//  verbose      0                    1 = $display trace, simulation only
// PORTS
//  clk                 in   1          clock, rising edge
//  reset               in   1          asynchronous, active-high
//  go                  in   1          start request, sampled on rising clk in IDLE only
//  x                   in   3          pixel row in block, sampled with go
//  y                   in   3          pixel column in block, sampled with go
//  coef_rd_addr        out  6          coefficient index u*8+v
//  coef_y_in           in   q_full     signed Y coefficient; valid 1 cycle after coef_rd_addr
//  coef_cb_in          in   q_full     signed Cb coefficient; same timing
//  coef_cr_in          in   q_full     signed Cr coefficient; same timing
//  pixel_out           out  24         {Y[23:16],Cb[15:8],Cr[7:0]}, held until next finish
//  busy                out  1          high from FETCH through OUT
//  idct_finished_flag  out  1          one-cycle pulse in OUT
// BEHAVIOUR
//  - Reset values: pixel_out=0, busy=0, idct_finished_flag=0, coef_rd_addr=0.
//    All accumulators and u,v cleared; FSM goes to IDLE.
//  - FSM states: IDLE -> FETCH -> WAIT -> MAC -> (FETCH | SCALE) -> OUT -> IDLE.
//  - IDLE: when go=1, latch x,y, clear accumulators, set u=v=0, go to FETCH.
//  - FETCH: drive ROM address and coef_rd_addr. WAIT: ROM and coefficient data become valid.
//  - MAC: w = (u==0 ? 1/sqrt2 : 1) * (v==0 ? 1/sqrt2 : 1).
//    acc_c += signed_mult(signed_mult(coef_c, w), const), for c in {Y,Cb,Cr}.
//  - MAC then steps v; when v wraps 7->0 it steps u. After term 63 (u=v=7), go to SCALE, else FETCH.
//  - SCALE: r = acc*1/4, rounded half-up at bit q_half-1, then integer part taken.
//    Clamp: r<0 -> 0; r>255 -> 255.
//  - OUT: register pixel_out, pulse idct_finished_flag, go to IDLE.
//  - Latency: idct_finished_flag is high exactly 194 cycles after the edge that samples go
//    (64 terms x 3 cycles, plus SCALE, plus OUT).
//  - go while busy is ignored; no queuing.
//  - go held high gives back-to-back pixels; each new start is sampled in IDLE one cycle after OUT.
//  - Accumulators are q_full+acc_guard bits wide, so there is no intermediate overflow.
//    The clamp is the only saturation point.
//  - Reset mid-operation aborts immediately. No finish pulse is produced; pixel_out is cleared.
// CONFIGURATION
//  - Macro: IDCT_CHROMA_EN.
//  - Defined: Cb and Cr lanes are accumulated and output as above.
//  - Undefined: chroma lanes are not built, coef_cb_in and coef_cr_in are ignored,
//    pixel_out[15:0] is constant 16'h8080, and Y timing is unchanged.
// STRUCTURE
//  - Shared package (nt_aeb): one, one_over_sqrt_2, one_over_4_signed, signed_mult, and the FSM state encoding.
//  - Sub-module idct_mac_lane: one accumulator plus round/clamp, instantiated for Y
//    and (with IDCT_CHROMA_EN) for Cb and Cr.
//  - Constant ROM: memory_list_signed, mem_depth 4096.
// TESTING
//  1. Coefficient buffer with Y[0]=1024.0, all others 0, and go at (3,5) -> Y byte=128 at finish; busy is high 194 cycles.
//  2. Y[0]=2400.0 -> Y byte=255. Y[0]=-80.0 -> Y byte=0. Confirms clamp in both directions.
//  3. Forward-DCT output of a ramp block p(x,y)=16x+8y, then all 64 (x,y) inverted -> each byte within +/-1 of p.
//  4. Second go pulses at cycles 10 and 100 after the first start -> exactly one finish pulse; pixel_out is from the first request.
//  5. reset asserted at cycle 50 of a run -> busy=0 and pixel_out=0 asynchronously, no finish pulse.
//     A new go after release completes normally.
//  6. Build without IDCT_CHROMA_EN, Cb[0]=Cr[0]=512.0 -> pixel_out[15:0]=16'h8080.
//     With the macro defined the same stimulus gives 16'h4040.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared fixed-point constants, helpers and FSM encoding for the idct slice.
// Chroma lanes are built only with IDCT_CHROMA_EN defined.
package idct_pkg;

   localparam int unsigned Q_FULL    = 32;
   localparam int unsigned Q_HALF    = 16;
   localparam int unsigned ACC_GUARD = 6;
   localparam int unsigned ACC_W     = Q_FULL + ACC_GUARD;
   localparam int unsigned MEM_DEPTH = 4096;

   localparam logic signed [Q_FULL-1:0] ONE               = 32'sd65536;
   localparam logic signed [Q_FULL-1:0] ONE_OVER_SQRT_2   = 32'sd46341;
   localparam logic signed [Q_FULL-1:0] ONE_OVER_4_SIGNED = 32'sd16384;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_MAC,
      ST_SCALE,
      ST_OUT
   } state_t;

   // Q16.16 multiply, fractional part truncated.
   function automatic logic signed [Q_FULL-1:0] signed_mult(input logic signed [Q_FULL-1:0] a,
                                                            input logic signed [Q_FULL-1:0] b);
      logic signed [2*Q_FULL-1:0] p;
      p = (2*Q_FULL)'(a) * (2*Q_FULL)'(b);
      return Q_FULL'(p >>> Q_HALF);
   endfunction

   // cos(k*pi/16) in Q16.16 for any k modulo 32.
   function automatic logic signed [Q_FULL-1:0] cos_q(input logic [4:0] k);
      logic [4:0]               m;
      logic                     neg;
      logic [3:0]               i;
      logic signed [Q_FULL-1:0] c;
      m   = (k > 5'd16) ? (5'd0 - k) : k;
      neg = (m > 5'd8);
      i   = neg ? 4'(5'd16 - m) : 4'(m);
      case (i)
         4'd0:    c = 32'sd65536;
         4'd1:    c = 32'sd64277;
         4'd2:    c = 32'sd60547;
         4'd3:    c = 32'sd54491;
         4'd4:    c = 32'sd46341;
         4'd5:    c = 32'sd36410;
         4'd6:    c = 32'sd25080;
         4'd7:    c = 32'sd12785;
         default: c = 32'sd0;
      endcase
      return neg ? -c : c;
   endfunction

   // Basis term cos(x,u)*cos(y,v) for address {u,v,x,y}.
   function automatic logic signed [Q_FULL-1:0] basis_const(input logic [11:0] a);
      logic [4:0] ku;
      logic [4:0] kv;
      ku = 5'(5'({a[5:3], 1'b1}) * 5'(a[11:9]));
      kv = 5'(5'({a[2:0], 1'b1}) * 5'(a[8:6]));
      return signed_mult(cos_q(ku), cos_q(kv));
   endfunction

   function automatic logic signed [Q_FULL-1:0] basis_weight(input logic [2:0] u,
                                                             input logic [2:0] v);
      logic signed [Q_FULL-1:0] wu;
      logic signed [Q_FULL-1:0] wv;
      wu = (u == 3'd0) ? ONE_OVER_SQRT_2 : ONE;
      wv = (v == 3'd0) ? ONE_OVER_SQRT_2 : ONE;
      return signed_mult(wu, wv);
   endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One colour lane: coefficient latch, weighted MAC accumulator, quarter scale, round and clamp.
module idct_mac_lane
   import idct_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     latch,
   input  logic                     mac_en,
   input  logic signed [Q_FULL-1:0] coef_in,
   input  logic signed [Q_FULL-1:0] w,
   input  logic signed [Q_FULL-1:0] k,
   output logic [7:0]               pix_c
);

   localparam int unsigned PW = ACC_W + Q_FULL;

   logic signed [ACC_W-1:0]  acc;
   logic signed [Q_FULL-1:0] coef_q;
   logic signed [Q_FULL-1:0] term_c;
   logic signed [PW-1:0]     prod_c;
   logic signed [PW-1:0]     rnd_c;
   logic signed [PW-1:0]     ip_c;

   assign term_c = signed_mult(signed_mult(coef_q, w), k);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         coef_q <= '0;
      end else begin
         if (latch) coef_q <= coef_in;
         if (clr)         acc <= '0;
         else if (mac_en) acc <= acc + ACC_W'(term_c);
      end
   end

   // acc/4, round half-up at the binary point, then saturate to a byte.
   always_comb begin
      prod_c = PW'(acc) * PW'(ONE_OVER_4_SIGNED);
      rnd_c  = (prod_c >>> Q_HALF) + (PW'(1) <<< (Q_HALF - 1));
      ip_c   = rnd_c >>> Q_HALF;
      if (ip_c[PW-1])            pix_c = 8'd0;
      else if (ip_c > PW'(255))  pix_c = 8'd255;
      else                       pix_c = ip_c[7:0];
   end

endmodule

// File: rtl/memory_list_signed.sv
// Basis-constant ROM, one-cycle registered read; contents come from the package cosine table.
module memory_list_signed
   import idct_pkg::*;
#(
   parameter int unsigned mem_depth   = MEM_DEPTH,
   parameter int unsigned address_len = 12
) (
   input  logic                     clk,
   input  logic [address_len-1:0]   addr,
   output logic signed [Q_FULL-1:0] data
);

   always_ff @(posedge clk) begin
      if (32'(addr) < mem_depth) data <= basis_const(addr[11:0]);
      else                       data <= '0;
   end

endmodule

// File: rtl/idct.sv
// Single-pixel 8x8 inverse DCT: 64 fetch/wait/mac terms, then scale and output.
// Macro IDCT_CHROMA_EN builds the Cb/Cr lanes; otherwise chroma reads as 16'h8080.
module idct
   import idct_pkg::*;
#(
   parameter int unsigned q_full      = Q_FULL,
   parameter int unsigned address_len = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go,
   input  logic [2:0]               x,
   input  logic [2:0]               y,
   output logic [5:0]               coef_rd_addr,
   input  logic signed [q_full-1:0] coef_y_in,
   input  logic signed [q_full-1:0] coef_cb_in,
   input  logic signed [q_full-1:0] coef_cr_in,
   output logic [23:0]              pixel_out,
   output logic                     busy,
   output logic                     idct_finished_flag
);

   state_t                   state;
   logic [2:0]               px;
   logic [2:0]               py;
   logic signed [Q_FULL-1:0] rom_data;
   logic signed [Q_FULL-1:0] w_c;
   logic                     clr_c;
   logic                     latch_c;
   logic                     mac_c;
   logic [7:0]               y_pix_c;
   logic [15:0]              chroma_c;

   assign clr_c   = (state == ST_IDLE) && go;
   assign latch_c = (state == ST_WAIT);
   assign mac_c   = (state == ST_MAC);
   assign w_c     = basis_weight(coef_rd_addr[5:3], coef_rd_addr[2:0]);

   memory_list_signed #(
      .mem_depth   (MEM_DEPTH),
      .address_len (address_len)
   ) u_rom (
      .clk  (clk),
      .addr (address_len'({coef_rd_addr, px, py})),
      .data (rom_data)
   );

   idct_mac_lane u_lane_y (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_c),
      .latch   (latch_c),
      .mac_en  (mac_c),
      .coef_in (coef_y_in),
      .w       (w_c),
      .k       (rom_data),
      .pix_c   (y_pix_c)
   );

`ifdef IDCT_CHROMA_EN
   logic [7:0] cb_pix_c;
   logic [7:0] cr_pix_c;

   idct_mac_lane u_lane_cb (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_c),
      .latch   (latch_c),
      .mac_en  (mac_c),
      .coef_in (coef_cb_in),
      .w       (w_c),
      .k       (rom_data),
      .pix_c   (cb_pix_c)
   );

   idct_mac_lane u_lane_cr (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_c),
      .latch   (latch_c),
      .mac_en  (mac_c),
      .coef_in (coef_cr_in),
      .w       (w_c),
      .k       (rom_data),
      .pix_c   (cr_pix_c)
   );

   assign chroma_c = {cb_pix_c, cr_pix_c};
`else
   logic chroma_unused;
   assign chroma_unused = ^{coef_cb_in, coef_cr_in};
   assign chroma_c      = 16'h8080;
`endif

   // coef_rd_addr doubles as the {u,v} term counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= ST_IDLE;
         coef_rd_addr       <= 6'd0;
         px                 <= 3'd0;
         py                 <= 3'd0;
         busy               <= 1'b0;
         idct_finished_flag <= 1'b0;
         pixel_out          <= 24'd0;
      end else begin
         idct_finished_flag <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go) begin
                  px           <= x;
                  py           <= y;
                  coef_rd_addr <= 6'd0;
                  busy         <= 1'b1;
                  state        <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_WAIT;
            ST_WAIT:  state <= ST_MAC;
            ST_MAC: begin
               coef_rd_addr <= coef_rd_addr + 6'd1;
               state        <= (coef_rd_addr == 6'd63) ? ST_SCALE : ST_FETCH;
            end
            ST_SCALE: begin
               pixel_out          <= {y_pix_c, chroma_c};
               idct_finished_flag <= 1'b1;
               state              <= ST_OUT;
            end
            ST_OUT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_idct.sv
// Scoreboard bench for idct: directed coefficient blocks, expected pixels queued per start.
module tb_idct;

   logic               clk = 1'b0;
   logic               reset;
   logic               go;
   logic [2:0]         x;
   logic [2:0]         y;
   logic [5:0]         coef_rd_addr;
   logic signed [31:0] coef_y_in;
   logic signed [31:0] coef_cb_in;
   logic signed [31:0] coef_cr_in;
   logic [23:0]        pixel_out;
   logic               busy;
   logic               idct_finished_flag;

   always #5 clk = ~clk;

   idct dut (
      .clk                (clk),
      .reset              (reset),
      .go                 (go),
      .x                  (x),
      .y                  (y),
      .coef_rd_addr       (coef_rd_addr),
      .coef_y_in          (coef_y_in),
      .coef_cb_in         (coef_cb_in),
      .coef_cr_in         (coef_cr_in),
      .pixel_out          (pixel_out),
      .busy               (busy),
      .idct_finished_flag (idct_finished_flag)
   );

`ifdef IDCT_CHROMA_EN
   localparam logic [15:0] LO_ZERO = 16'h0000;
   localparam logic [15:0] LO_512  = 16'h4040;
`else
   localparam logic [15:0] LO_ZERO = 16'h8080;
   localparam logic [15:0] LO_512  = 16'h8080;
`endif

   logic signed [31:0] cy [64];
   logic signed [31:0] ccb[64];
   logic signed [31:0] ccr[64];

   // Coefficient buffer: registered read, data one cycle after the address.
   always @(posedge clk) begin
      coef_y_in  <= cy[coef_rd_addr];
      coef_cb_in <= ccb[coef_rd_addr];
      coef_cr_in <= ccr[coef_rd_addr];
   end

   typedef struct {
      int          y;
      int          tol;
      logic [15:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      n_vec++;
      if (!ok) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every finish pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      int   dy;
      forever begin
         @(negedge clk);
         if (idct_finished_flag === 1'b1) begin
            check("finish_expected", sb.size() > 0, sb.size(), 1);
            if (sb.size() > 0) begin
               e  = sb.pop_front();
               dy = int'(pixel_out[23:16]) - e.y;
               check("y_byte", (dy <= e.tol) && (dy >= -e.tol), pixel_out[23:16], e.y);
               check("chroma", pixel_out[15:0] === e.lo, pixel_out[15:0], e.lo);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_buf();
      for (int i = 0; i < 64; i++) begin
         cy[i]  = 32'sd0;
         ccb[i] = 32'sd0;
         ccr[i] = 32'sd0;
      end
   endtask

   function automatic real cf(int a, int b);
      return $cos(real'((2 * a + 1) * b) * 3.14159265358979 / 16.0);
   endfunction

   // Forward DCT of p(x,y)=16x+8y into the Y buffer.
   task automatic load_ramp();
      real s;
      real f;
      clear_buf();
      for (int u = 0; u < 8; u++) begin
         for (int v = 0; v < 8; v++) begin
            s = 0.0;
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < 8; j++)
                  s = s + real'(16 * i + 8 * j) * cf(i, u) * cf(j, v);
            f = 0.25 * ((u == 0) ? 0.70710678118 : 1.0) * ((v == 0) ? 0.70710678118 : 1.0) * s;
            cy[u * 8 + v] = $rtoi(f * 65536.0 + ((f >= 0.0) ? 0.5 : -0.5));
         end
      end
   endtask

   task automatic push(input int ye, input int tol, input logic [15:0] lo);
      exp_t e;
      e.y   = ye;
      e.tol = tol;
      e.lo  = lo;
      sb.push_back(e);
   endtask

   task automatic start(input logic [2:0] xi, input logic [2:0] yi);
      @(negedge clk);
      x  = xi;
      y  = yi;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", k < 600, k, 600);
   endtask

   initial begin
      int first_flag;
      int busy_cnt;
      int flag_cnt;

      reset = 1'b1;
      go    = 1'b0;
      x     = 3'd0;
      y     = 3'd0;
      clear_buf();
      repeat (3) @(negedge clk);
      check("rst_pixel", pixel_out === 24'd0, pixel_out, 0);
      check("rst_busy", busy === 1'b0, busy, 0);
      check("rst_flag", idct_finished_flag === 1'b0, idct_finished_flag, 0);
      check("rst_addr", coef_rd_addr === 6'd0, coef_rd_addr, 0);
      reset = 1'b0;
      @(negedge clk);

      // DC only at (3,5): 1024*0.5/4 = 128; latency and busy width.
      cy[0] = 32'sd67108864;
      push(128, 0, LO_ZERO);
      x  = 3'd3;
      y  = 3'd5;
      go = 1'b1;
      @(posedge clk);
      first_flag = -1;
      busy_cnt   = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1) go = 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (idct_finished_flag === 1'b1 && first_flag < 0) first_flag = k;
         if (k > 1 && busy === 1'b0) break;
      end
      check("latency", first_flag == 194, first_flag, 194);
      check("busy_cycles", busy_cnt == 194, busy_cnt, 194);
      repeat (3) @(negedge clk);
      check("pixel_hold", pixel_out[23:16] === 8'd128, pixel_out[23:16], 128);

      // Clamp high and low.
      cy[0] = 32'sd157286400;
      push(255, 0, LO_ZERO);
      start(3'd0, 3'd0);
      wait_done();
      cy[0] = -32'sd5242880;
      push(0, 0, LO_ZERO);
      start(3'd4, 3'd1);
      wait_done();

      // Chroma DC 512 -> 0x40 per lane when built.
      cy[0]  = 32'sd67108864;
      ccb[0] = 32'sd33554432;
      ccr[0] = 32'sd33554432;
      push(128, 0, LO_512);
      start(3'd2, 3'd6);
      wait_done();

      // Ramp block, every position.
      load_ramp();
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            push(16 * i + 8 * j, 1, LO_ZERO);
            start(3'(i), 3'(j));
            wait_done();
         end
      end

      // go while busy is ignored: one finish, value from (1,2).
      push(32, 1, LO_ZERO);
      @(negedge clk);
      x  = 3'd1;
      y  = 3'd2;
      go = 1'b1;
      flag_cnt = 0;
      for (int k = 1; k <= 450; k++) begin
         @(negedge clk);
         case (k)
            1:       go = 1'b0;
            9:       begin go = 1'b1; x = 3'd6; y = 3'd6; end
            10:      go = 1'b0;
            99:      go = 1'b1;
            100:     go = 1'b0;
            default: ;
         endcase
         if (idct_finished_flag === 1'b1) flag_cnt++;
      end
      check("single_finish", flag_cnt == 1, flag_cnt, 1);

      // Reset mid-run aborts at once, then a fresh run completes.
      @(negedge clk);
      x  = 3'd7;
      y  = 3'd7;
      go = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 1) go = 1'b0;
      end
      check("busy_mid_run", busy === 1'b1, busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", busy === 1'b0, busy, 0);
      check("abort_pixel", pixel_out === 24'd0, pixel_out, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push(0, 1, LO_ZERO);
      start(3'd0, 3'd0);
      wait_done();

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
